// File: rtl/uart_pkg.sv
// Shared UART definitions: issue FSM state encoding and default sizing
// constants used by the transmit queue and its neighbouring UART blocks.
package uart_pkg;

  // Default character width; must match the downstream transmitter.
  localparam int unsigned PAYLOAD_BITS_DEF = 8;

  // Default queue depth; a power of two, at least 2.
  localparam int unsigned DEPTH_DEF = 16;

  // Issue FSM: IDLE waits for a character and a free transmitter, ISSUE
  // holds the one-cycle send request, ARMED waits for the transmitter to
  // pick it up (busy rises), DRAIN waits for the frame to end (busy falls).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARMED = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count. Flush clears pointers and count
// and overrides any same-cycle push or pop. A push on a full queue is
// dropped even when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_push_fire;
  logic w_pop_fire;

  assign w_full  = (r_count == FULL_COUNT);
  assign w_empty = (r_count == '0);

  // Full is judged on the registered count, so a pop in the same cycle
  // does not open a slot for a push.
  assign w_push_fire = i_push && !w_full  && !i_flush;
  assign w_pop_fire  = i_pop  && !w_empty && !i_flush;

  // Storage write at the tail.
  // NOTE: the data array has no reset; only pointers and count define
  // which entries are valid, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (w_push_fire) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and count bookkeeping; pointers wrap naturally modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_empty    = w_empty;

endmodule : uart_sync_fifo

// File: rtl/uart_tx_queue.sv
// Transmit queue in front of a UART transmitter. Characters are buffered
// in a FIFO and handed out one at a time: a one-cycle uart_tx_en request,
// then a wait for the transmitter's busy to rise and fall before the next.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    push_valid,
  input  logic [PAYLOAD_BITS-1:0] push_data,
  output logic                    push_ready,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy
);

  tx_state_e               r_state;
  logic                    r_tx_en;
  logic [PAYLOAD_BITS-1:0] r_tx_data;

  logic                    w_pop;
  logic [PAYLOAD_BITS-1:0] w_head;
  logic                    w_full;
  logic                    w_empty;

  // Pop only from IDLE with data waiting and a free transmitter; flush
  // inhibits the pop so a discarded queue never issues a character.
  assign w_pop = (r_state == IDLE) && !w_empty && !uart_tx_busy && !flush;

  uart_sync_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (push_valid),
    .i_push_data (push_data),
    .i_pop       (w_pop),
    .i_flush     (flush),
    .o_pop_data  (w_head),
    .o_count     (fifo_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Issue FSM with registered request and data; flush never touches it,
  // so a frame already issued always runs to completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
    end else begin
      // NOTE: the request defaults low every cycle and is raised only on
      // the edge entering ISSUE, which makes it a single-cycle pulse.
      r_tx_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state   <= ISSUE;
            r_tx_en   <= 1'b1;
            r_tx_data <= w_head;
          end
        end
        ISSUE: begin
          r_state <= ARMED;
        end
        ARMED: begin
          if (uart_tx_busy) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!uart_tx_busy) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign push_ready   = !w_full;
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;

endmodule : uart_tx_queue

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter PAYLOAD_BITS, default 8: width of each queued character; SHALL match the downstream transmitter.
REQ-002 Parameter DEPTH, default 16: queue entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  system clock; the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 resetn  input  1  reset, synchronous and active-low.
REQ-005 push_valid  input  1  producer offers push_data this cycle.
REQ-006 push_data  input  PAYLOAD_BITS  character to enqueue.
REQ-007 push_ready  output  1  queue can accept a character; SHALL equal (fifo_count != DEPTH).
REQ-008 flush  input  1  discard all queued characters.
REQ-009 fifo_count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-010 fifo_empty / fifo_full  output  1 each  SHALL equal count==0 / count==DEPTH.
REQ-011 uart_tx_en  output  1  one-cycle send request to the transmitter.
REQ-012 uart_tx_data  output  PAYLOAD_BITS  character for the transmitter; held stable from the issue until the next pop.
REQ-013 uart_tx_busy  input  1  transmitter busy with a frame.

Function
REQ-014 Push handshake: a push SHALL be accepted only on a cycle where push_valid and push_ready are both 1; data is written at the tail.
REQ-015 The queue SHALL be strictly FIFO, with no bypass. A character pushed into an empty queue at cycle N SHALL be popped no earlier than cycle N+1, and uart_tx_en SHALL rise no earlier than N+2.
REQ-016 Issue FSM states SHALL be IDLE, ISSUE, ARMED, DRAIN.
REQ-017 IDLE -> ISSUE when !fifo_empty && !uart_tx_busy && !flush. On that edge the head SHALL be popped into uart_tx_data and count decremented.
REQ-018 ISSUE: uart_tx_en=1 for exactly this one cycle; the FSM then moves unconditionally to ARMED.
REQ-019 ARMED: wait for uart_tx_busy=1, then move to DRAIN.
REQ-020 DRAIN: wait for uart_tx_busy=0, then move to IDLE.
REQ-021 uart_tx_en SHALL be registered and SHALL be 0 in every state except ISSUE; two requests SHALL never occur without an intervening busy high-low cycle.
REQ-022 Simultaneous push and pop on a non-empty queue SHALL leave count unchanged; both operations take effect.
REQ-023 When full, push_ready=0 and push_valid SHALL be ignored, even on the cycle a pop occurs.
REQ-024 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH with no gap.
REQ-025 flush SHALL zero both pointers and count next cycle, and SHALL win over a same-cycle push (push dropped) and pop (pop inhibited).
REQ-026 flush SHALL NOT abort a frame already issued: the FSM state, uart_tx_data and uart_tx_en SHALL be unaffected.

Reset
REQ-027 While resetn=0 at a clock edge, the following SHALL be set: FSM=IDLE, pointers=0, count=0, uart_tx_en=0, uart_tx_data=0.
REQ-028 After reset: push_ready=1, fifo_empty=1, fifo_full=0, fifo_count=0.
REQ-029 Reset mid-frame SHALL discard the queue and return to IDLE without waiting for uart_tx_busy.
REQ-030 Storage array contents SHALL not require reset.

Structure
REQ-031 Package uart_pkg SHALL hold the FSM state enum (2 bits) and the default PAYLOAD_BITS/DEPTH constants, shared with the UART blocks.
REQ-032 Storage and pointer/count logic SHALL be a sub-module uart_sync_fifo (push, pop, flush, count, full, empty). uart_tx_queue adds the issue FSM.
REQ-033 Target size: 120-400 lines of RTL total.

Verification
REQ-034 Reset, push 0x41 at cycle N with uart_tx_busy=0 -> pop at N+1, uart_tx_en=1 only at N+2, uart_tx_data=0x41, count back to 0.
REQ-035 Push 0x01..0x10 back-to-back with busy held 1 -> push_ready=0 after the 16th push, fifo_full=1, 17th push_valid ignored.
REQ-036 Connect a real uart_tx, push "ABC" -> exactly three uart_tx_en pulses, each after busy falls, line decodes 0x41,0x42,0x43 in order.
REQ-037 Full queue, pop and push_valid in same cycle -> push rejected, count=15. Half-full queue, pop and push together -> count unchanged.
REQ-038 Queue of 5 with a frame in DRAIN, assert flush together with push_valid -> count=0, pushed byte absent, in-flight frame completes, no further uart_tx_en.
REQ-039 Drive resetn=0 in ARMED with 3 queued -> next cycle FSM=IDLE, count=0, uart_tx_en=0; 20 random push/flush cycles across pointer wrap match a reference queue model.
